// File: rtl/sva_seq_checker.sv
// sva_seq_checker
//   Multi-thread evaluator for the sequence step0 ##1 step1 ##1 ... ##1 step[STEPS-1]
//   over a sampled vector. Each step is a masked compare against sig. Overlapping
//   attempts occupy a fixed table of NUM_THR slots. Work happens only on samples
//   qualified by smp_en.
// Ports
//   sys_clk, sys_rst_n      clock, async active-low reset
//   smp_en                  sample strobe, one evaluation per high cycle
//   clr                     sync clear of slots, counters and sticky flag (beats smp_en)
//   sig[NUM_SIG]            sampled vector
//   succ / fail / ovf       one-cycle result pulses for the previous sample
//   ovf_sticky              latched ovf, cleared by clr or reset
//   busy / active_cnt       slot occupancy after the last sample
//   succ_cnt / fail_cnt     saturating result counters
module sva_seq_checker #(
    parameter int NUM_SIG = 3,
    parameter int STEPS   = 4,
    parameter int NUM_THR = 4,
    parameter logic [STEPS*NUM_SIG-1:0] MASK = '1,
    parameter logic [STEPS*NUM_SIG-1:0] VAL  = '1,
    parameter int MODE    = 0,
    parameter int CNT_W   = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         smp_en,
    input  logic                         clr,
    input  logic [NUM_SIG-1:0]           sig,
    output logic                         succ,
    output logic                         fail,
    output logic                         ovf,
    output logic                         ovf_sticky,
    output logic                         busy,
    output logic [$clog2(NUM_THR+1)-1:0] active_cnt,
    output logic [CNT_W-1:0]             succ_cnt,
    output logic [CNT_W-1:0]             fail_cnt
);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int AW     = $clog2(NUM_THR + 1);
    // per-sample result count: up to NUM_THR completions plus the new attempt
    localparam int NW     = $clog2(NUM_THR + 2);
    localparam int SW     = CNT_W + NW;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    generate
        if (STEPS < 1 || STEPS > 16) begin : g_bad_steps
            $error("sva_seq_checker: STEPS must be in 1..16");
        end
        if (NUM_THR < 1 || NUM_THR > 16) begin : g_bad_thr
            $error("sva_seq_checker: NUM_THR must be in 1..16");
        end
    endgenerate

    function automatic logic step_match(input logic [NUM_SIG-1:0] s, input int k);
        return ((s ^ VAL[k*NUM_SIG +: NUM_SIG]) & MASK[k*NUM_SIG +: NUM_SIG]) == '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [NW-1:0] b);
        logic [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        return (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [NUM_THR-1:0]             r_act;
    logic [NUM_THR-1:0][STEP_W-1:0] r_step;
    logic                           r_succ, r_fail, r_ovf, r_ovf_sticky, r_busy;
    logic [AW-1:0]                  r_active_cnt;
    logic [CNT_W-1:0]               r_succ_cnt, r_fail_cnt;

    logic [NUM_THR-1:0]             w_act_nxt;
    logic [NUM_THR-1:0][STEP_W-1:0] w_step_nxt;
    logic [NW-1:0]                  w_n_succ, w_n_fail;
    logic [AW-1:0]                  w_acnt_nxt;
    logic                           w_ovf, w_found, w_m0;

    always_comb begin
        w_act_nxt  = r_act;
        w_step_nxt = r_step;
        w_n_succ   = '0;
        w_n_fail   = '0;
        w_ovf      = 1'b0;
        w_found    = 1'b0;
        w_acnt_nxt = '0;
        w_m0       = step_match(sig, 0);

        // advance or retire every running attempt
        for (int i = 0; i < NUM_THR; i++) begin
            if (r_act[i]) begin
                if (step_match(sig, int'(r_step[i]))) begin
                    if (r_step[i] == LAST) begin
                        w_act_nxt[i] = 1'b0;
                        w_n_succ     = w_n_succ + NW'(1);
                    end else begin
                        w_step_nxt[i] = r_step[i] + STEP_W'(1);
                    end
                end else begin
                    w_act_nxt[i] = 1'b0;
                    w_n_fail     = w_n_fail + NW'(1);
                end
            end
        end

        // new attempt; only slots free before this sample are candidates,
        // so a slot retired above is not handed out again this cycle
        if (!w_m0) begin
            if (MODE == 0) w_n_fail = w_n_fail + NW'(1);
        end else if (STEPS == 1) begin
            w_n_succ = w_n_succ + NW'(1);
        end else begin
            for (int i = 0; i < NUM_THR; i++) begin
                if (!r_act[i] && !w_found) begin
                    w_act_nxt[i]  = 1'b1;
                    w_step_nxt[i] = STEP_W'(1);
                    w_found       = 1'b1;
                end
            end
            if (!w_found) w_ovf = 1'b1;
        end

        for (int i = 0; i < NUM_THR; i++) w_acnt_nxt = w_acnt_nxt + AW'(w_act_nxt[i]);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_act <= '0; r_step <= '0;
            r_succ <= 1'b0; r_fail <= 1'b0; r_ovf <= 1'b0; r_ovf_sticky <= 1'b0;
            r_busy <= 1'b0; r_active_cnt <= '0; r_succ_cnt <= '0; r_fail_cnt <= '0;
        end else if (clr) begin
            r_act <= '0; r_step <= '0;
            r_succ <= 1'b0; r_fail <= 1'b0; r_ovf <= 1'b0; r_ovf_sticky <= 1'b0;
            r_busy <= 1'b0; r_active_cnt <= '0; r_succ_cnt <= '0; r_fail_cnt <= '0;
        end else if (smp_en) begin
            r_act        <= w_act_nxt;
            r_step       <= w_step_nxt;
            r_succ       <= (w_n_succ != '0);
            r_fail       <= (w_n_fail != '0);
            r_ovf        <= w_ovf;
            if (w_ovf) r_ovf_sticky <= 1'b1;
            r_busy       <= |w_act_nxt;
            r_active_cnt <= w_acnt_nxt;
            r_succ_cnt   <= sat_add(r_succ_cnt, w_n_succ);
            r_fail_cnt   <= sat_add(r_fail_cnt, w_n_fail);
        end else begin
            r_succ <= 1'b0;
            r_fail <= 1'b0;
            r_ovf  <= 1'b0;
        end
    end

    assign succ       = r_succ;
    assign fail       = r_fail;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_ovf_sticky;
    assign busy       = r_busy;
    assign active_cnt = r_active_cnt;
    assign succ_cnt   = r_succ_cnt;
    assign fail_cnt   = r_fail_cnt;
endmodule
